lcd_op_display: RTL



---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_write_strobe.sv | 66 ++++++
 rtl/lcd_op_display.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the operator-character LCD path.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_FUNC,
        ST_INIT_DISP,
        ST_INIT_ENTRY,
        ST_INIT_CLEAR,
        ST_SET_ADDR,
        ST_WRITE_CHAR,
        ST_IDLE
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } wr_phase_t;

    localparam logic [7:0] LCD_CMD_FUNC    = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP    = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_SETADDR = 8'h80;
    localparam logic [7:0] LCD_BLANK       = 8'h20;

endpackage

// File: rtl/lcd_write_strobe.sv
// Three-phase LCD write engine: SETUP (e=0), STROBE (e=1), HOLD (e=0).
// rs/data are captured on start and held until the next accepted start.
module lcd_write_strobe
    import lcd_pkg::*;
(
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_e,
    output logic       o_rs,
    output logic [7:0] o_data,
    output logic       o_done
);

    wr_phase_t  phase_q, phase_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            phase_q <= WR_IDLE;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        e_d     = 1'b0;
        rs_d    = rs_q;
        data_d  = data_q;
        case (phase_q)
            WR_IDLE, WR_HOLD: begin
                // A start in HOLD chains straight into the next SETUP.
                if (i_start) begin
                    phase_d = WR_SETUP;
                    rs_d    = i_rs;
                    data_d  = i_data;
                end else begin
                    phase_d = WR_IDLE;
                end
            end
            WR_SETUP: begin
                phase_d = WR_STROBE;
                e_d     = 1'b1;
            end
            WR_STROBE: phase_d = WR_HOLD;
            default:   phase_d = WR_IDLE;
        endcase
    end

    assign o_e    = e_q;
    assign o_rs   = rs_q;
    assign o_data = data_q;
    assign o_done = (phase_q == WR_HOLD);

endmodule

// File: rtl/lcd_op_display.sv
// HD44780 init sequencer plus change-driven rewrite of one operator character.
module lcd_op_display
    import lcd_pkg::*;
#(
    parameter int         POWERUP_CYCLES = 10,
    parameter logic [6:0] CHAR_ADDR      = 7'h0F
) (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic [7:0] i_char,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       o_busy
);

    localparam int             CNT_W    = $clog2(POWERUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [7:0]     CMD_ADDR = LCD_CMD_SETADDR | {1'b0, CHAR_ADDR};

    lcd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       shown_q, shown_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;

    logic       wr_start, wr_rs, wr_done;
    logic [7:0] wr_data;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_POWERUP;
            cnt_q     <= '0;
            pending_q <= LCD_BLANK;
            shown_q   <= LCD_BLANK;
            first_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        shown_d   = shown_q;
        first_d   = first_q;
        wr_start  = 1'b0;
        wr_rs     = 1'b0;
        wr_data   = 8'h00;
        case (state_q)
            ST_POWERUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_INIT_FUNC;
                    wr_start = 1'b1;
                    wr_data  = LCD_CMD_FUNC;
                end
            end
            ST_INIT_FUNC: if (wr_done) begin
                state_d  = ST_INIT_DISP;
                wr_start = 1'b1;
                wr_data  = LCD_CMD_DISP;
            end
            ST_INIT_DISP: if (wr_done) begin
                state_d  = ST_INIT_ENTRY;
                wr_start = 1'b1;
                wr_data  = LCD_CMD_ENTRY;
            end
            ST_INIT_ENTRY: if (wr_done) begin
                state_d  = ST_INIT_CLEAR;
                wr_start = 1'b1;
                wr_data  = LCD_CMD_CLEAR;
            end
            ST_INIT_CLEAR: if (wr_done) begin
                state_d  = ST_SET_ADDR;
                wr_start = 1'b1;
                wr_data  = CMD_ADDR;
                first_d  = 1'b1;
            end
            ST_SET_ADDR: begin
                // First pass after init samples i_char in the SETUP cycle; later passes latched it in IDLE.
                if (first_q) begin
                    pending_d = i_char;
                    first_d   = 1'b0;
                end
                if (wr_done) begin
                    state_d  = ST_WRITE_CHAR;
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_data  = pending_q;
                end
            end
            ST_WRITE_CHAR: if (wr_done) begin
                state_d = ST_IDLE;
                shown_d = pending_q;
            end
            default: begin
                if (i_char != shown_q) begin
                    pending_d = i_char;
                    state_d   = ST_SET_ADDR;
                    wr_start  = 1'b1;
                    wr_data   = CMD_ADDR;
                end
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    lcd_write_strobe u_wr (
        .clk_100hz (clk_100hz),
        .rst       (rst),
        .i_start   (wr_start),
        .i_rs      (wr_rs),
        .i_data    (wr_data),
        .o_e       (lcd_e),
        .o_rs      (lcd_rs),
        .o_data    (lcd_data),
        .o_done    (wr_done)
    );

    assign lcd_rw = 1'b0;
    assign o_busy = busy_q;

endmodule
